// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I constants, decode instType encoding and fetch types
package rv32_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [3:0] {
        LOAD  = 4'd0,
        IMM   = 4'd1,
        STORE = 4'd2,
        REG   = 4'd3,
        LUI   = 4'd4,
        AUIPC = 4'd5,
        BRNCH = 4'd6,
        JALR  = 4'd7,
        JAL   = 4'd8
    } inst_type_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, inst} buffer with push, pop, clear and occupancy
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, credit-limited imem requests, redirect flush
// FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = FIFO_DEPTH[CW:0];

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
    fetch_entry_t  fifo_head, rsp_entry;
    logic          credit, req_fire, rsp_take, rsp_keep, bypass_hit;

    always_comb begin
        credit         = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_C;
        imem_req_valid = !rst && (state_q == RUN) && credit;
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        // A response with nothing outstanding belongs to a request issued before reset.
        rsp_take       = imem_rsp_valid && (outstanding_q != '0);
        rsp_keep       = rsp_take && (state_q == RUN) && !redirect_valid;
        rsp_entry.pc   = rsp_pc_q;
        rsp_entry.inst = imem_rsp_data;

`ifdef FETCH_BYPASS_EN
        bypass_hit = rsp_keep && fifo_empty;
`else
        bypass_hit = 1'b0;
`endif

        out_valid = !fifo_empty || bypass_hit;
        if (!fifo_empty) begin
            out_inst = fifo_head.inst;
            out_pc   = fifo_head.pc;
        end else if (bypass_hit) begin
            out_inst = rsp_entry.inst;
            out_pc   = rsp_entry.pc;
        end else begin
            out_inst = NOP_INST;
            out_pc   = '0;
        end

        fifo_pop  = !fifo_empty && out_ready;
        fifo_push = rsp_keep && !(bypass_hit && out_ready) && (!fifo_full || fifo_pop);

        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);

        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            pc_d     = word_align(redirect_pc);
            rsp_pc_d = word_align(redirect_pc);
        end

        // Stay in FLUSH until every request issued before the last redirect has returned.
        state_d = ((outstanding_d != '0) && (redirect_valid || (state_q == FLUSH))) ? FLUSH : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .din   (rsp_entry),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level fetch model
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_req_pc = RST_PC;
    logic [31:0] exp_out_pc = RST_PC;
    int          buffered   = 0;
    int          rst_cnt    = 0;
    int          rsp_pct    = 100;
    int          n_checks   = 0;
    int          n_err      = 0;
    int          n_req;
    bit          found;
    logic        s_req_v, s_out_v;
    logic [31:0] s_req_a, s_out_inst, s_out_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h030391b7;
            32'h0000_0104: return 32'h07b20193;
            32'h0000_0300: return 32'h08418063;
            default:       return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, drive memory at posedge+1.
    task automatic tick();
        bit exp_rv, exp_ov, stale_any, delivered;
        exp_ov = 1'b0;
        @(negedge clk);
        s_req_v    = imem_req_valid;
        s_req_a    = imem_req_addr;
        s_out_v    = out_valid;
        s_out_inst = out_inst;
        s_out_pc   = out_pc;
        stale_any  = 1'b0;
        foreach (pend[i]) if (pend[i].stale) stale_any = 1'b1;
        if (rst) begin
            if (rst_cnt > 0) begin
                chk("rst_req_valid", s_req_v, 0);
                chk("rst_out_valid", s_out_v, 0);
                chk("rst_out_inst", s_out_inst, NOP);
                chk("rst_out_pc", s_out_pc, 0);
            end
        end else begin
            exp_rv = !stale_any && ((pend.size() + buffered) < DEPTH);
            chk("req_valid", s_req_v, exp_rv);
            if (s_req_v) chk("req_addr", s_req_a, exp_req_pc);
            exp_ov = (buffered > 0);
`ifdef FETCH_BYPASS_EN
            if (imem_rsp_valid && !redirect_valid && pend.size() > 0 && !pend[0].stale) exp_ov = 1'b1;
`endif
            chk("out_valid", s_out_v, exp_ov);
            if (exp_ov) begin
                chk("out_pc", s_out_pc, exp_out_pc);
                chk("out_inst", s_out_inst, memf(exp_out_pc));
            end else begin
                chk("idle_out_inst", s_out_inst, NOP);
                chk("idle_out_pc", s_out_pc, 0);
            end
        end
        @(posedge clk);
        if (rst) begin
            rst_cnt++;
            pend.delete();
            buffered   = 0;
            exp_req_pc = RST_PC;
            exp_out_pc = RST_PC;
        end else begin
            rst_cnt   = 0;
            delivered = 1'b0;
            if (imem_rsp_valid && pend.size() > 0) begin
                delivered = !pend[0].stale && !redirect_valid;
                void'(pend.pop_front());
            end
            if (delivered) buffered++;
            if (exp_ov && out_ready) begin
                buffered--;
                exp_out_pc += 32'd4;
            end
            if (s_req_v && imem_req_ready) begin
                pend.push_back('{s_req_a, redirect_valid});
                exp_req_pc += 32'd4;
            end
            if (redirect_valid) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                buffered   = 0;
                exp_req_pc = {redirect_pc[31:2], 2'b00};
                exp_out_pc = exp_req_pc;
            end
        end
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Fill: two requests, then stall on credit with decode not consuming.
        tick();
        chk("first_req_valid", s_req_v, 1);
        chk("first_req_addr", s_req_a, RST_PC);
        tick();
        chk("second_req_addr", s_req_a, 32'h104);
        tick();
        chk("credit_stall", s_req_v, 0);
        chk("head0_inst", s_out_inst, 32'h030391b7);
        chk("head0_pc", s_out_pc, 32'h100);
        n_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_req_v) n_req++;
        end
        chk("no_req_when_full", n_req, 0);

        // One pop frees exactly one credit.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_head_pc", s_out_pc, 32'h100);
        tick();
        chk("refill_req_valid", s_req_v, 1);
        chk("refill_req_addr", s_req_a, 32'h108);
        chk("head1_inst", s_out_inst, 32'h07b20193);
        tick();
        chk("single_refill", s_req_v, 0);

        // Redirect with two requests outstanding.
        rsp_pct = 0;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (pend.size() == 2) && (buffered == 0);
        end
        chk("reach_two_outstanding", found, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        rsp_pct = 100;
        tick();
        chk("flush_no_req", s_req_v, 0);
        chk("flush_out_valid", s_out_v, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); found = s_req_v; end
        chk("redirect_req_seen", found, 1);
        chk("redirect_req_addr", s_req_a, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); found = s_out_v; end
        chk("redirect_out_seen", found, 1);
        chk("redirect_first_pc", s_out_pc, 32'h200);

        // Unaligned redirect landing on a response cycle.
        found = imem_rsp_valid;
        for (int i = 0; i < 10 && !found; i++) begin tick(); found = imem_rsp_valid; end
        chk("rsp_before_redirect", found, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("dropped_rsp_out_valid", s_out_v, 0);
        found = s_req_v;
        for (int i = 0; i < 10 && !found; i++) begin tick(); found = s_req_v; end
        chk("aligned_redirect_addr", s_req_a, 32'h200);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = s_req_v && (s_req_a == 32'hFFFF_FFFC) && imem_req_ready;
        end
        chk("top_req_seen", found, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); found = s_req_v; end
        chk("wrap_req_addr", s_req_a, 32'h0);

        // Response latency into an empty buffer with decode ready.
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = imem_rsp_valid && (imem_rsp_data == 32'h08418063);
        end
        chk("target_rsp_seen", found, 1);
        tick();
`ifdef FETCH_BYPASS_EN
        chk("bypass_same_cycle_valid", s_out_v, 1);
        chk("bypass_same_cycle_inst", s_out_inst, 32'h08418063);
`else
        chk("fifo_same_cycle_valid", s_out_v, 0);
        tick();
        chk("fifo_next_cycle_valid", s_out_v, 1);
        chk("fifo_next_cycle_inst", s_out_inst, 32'h08418063);
`endif

        // Randomised traffic with occasional redirects.
        rsp_pct = 60;
        for (int i = 0; i < 600; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;

        // Reset with requests in flight; a late response must be ignored.
        rsp_pct = 0; out_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("post_reset_rsp_ignored", s_out_v, 0);
        imem_req_ready = 1'b1; rsp_pct = 100; out_ready = 1'b1;
        tick();
        chk("post_reset_req_addr", s_req_a, RST_PC);
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
